// File: rtl/sram_bus_arbiter_if.sv
// One stall-based sram port: the requester drives en/we/addr/wdata, the arbiter returns rdata/stall/timeout.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              en;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              timeout;

    modport master (
        output en, we, addr, wdata,
        input  rdata, stall, timeout
    );

    modport slave (
        input  en, we, addr, wdata,
        output rdata, stall, timeout
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin share of one request/done memory port between ibus and dbus stall-based sram masters.
// One access outstanding; grant edge starts it, mem_done (or timeout) ends it, one idle bubble between accesses.
module sram_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_bus_arbiter_if.slave ibus,
    sram_bus_arbiter_if.slave dbus,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t r_state;
    state_t w_state_nxt;
    port_t  r_owner;
    port_t  r_last_grant;
    port_t  w_grant;
    logic   w_grant_vld;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ibus_rdata;
    logic [DATA_W-1:0] r_dbus_rdata;
    logic              r_ibus_timeout;
    logic              r_dbus_timeout;

    logic w_busy;
    logic w_i_match;
    logic w_d_match;
    logic w_match;
    logic w_done;
    logic w_expire;
    logic w_complete;
    logic w_end;
    logic w_is_read;

    // The mem_* registers double as the latched request record.
    assign w_i_match = ibus.en && (ibus.we == r_mem_we) && (ibus.addr == r_mem_addr)
                       && (ibus.wdata == r_mem_wdata);
    assign w_d_match = dbus.en && (dbus.we == r_mem_we) && (dbus.addr == r_mem_addr)
                       && (dbus.wdata == r_mem_wdata);
    assign w_match   = (r_owner == PORT_D) ? w_d_match : w_i_match;

    assign w_busy     = (r_state == BUSY);
    assign w_is_read  = (r_mem_we == 4'b0000);
    assign w_done     = w_busy && i_mem_done;
    // A done in the expiry cycle wins, so expiry requires its absence.
    assign w_expire   = TIMEOUT_EN && w_busy && !i_mem_done && (r_cnt == CNT_LAST);
    assign w_complete = (w_done && w_match) || w_expire;
    assign w_end      = w_done || w_expire;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_vld = 1'b0;
        w_grant     = PORT_I;
        case (r_state)
            IDLE: begin
                if (ibus.en || dbus.en) begin
                    w_grant_vld = 1'b1;
                    w_state_nxt = BUSY;
                    if (dbus.en && (!ibus.en || (r_last_grant == PORT_I))) begin
                        w_grant = PORT_D;
                    end
                end
            end
            BUSY: begin
                if (w_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_en       <= 1'b0;
            r_mem_we       <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_owner        <= PORT_I;
            r_last_grant   <= PORT_I;
            r_cnt          <= '0;
            r_ibus_rdata   <= '0;
            r_dbus_rdata   <= '0;
            r_ibus_timeout <= 1'b0;
            r_dbus_timeout <= 1'b0;
        end else begin
            if (w_grant_vld) begin
                r_mem_en     <= 1'b1;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= '0;
                if (w_grant == PORT_D) begin
                    r_mem_we    <= dbus.we;
                    r_mem_addr  <= dbus.addr;
                    r_mem_wdata <= dbus.wdata;
                end else begin
                    r_mem_we    <= ibus.we;
                    r_mem_addr  <= ibus.addr;
                    r_mem_wdata <= ibus.wdata;
                end
            end else if (w_end) begin
                r_mem_en <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // A timed-out read returns zero so the requester never consumes stale data.
            if (w_is_read && ((w_done && w_match) || w_expire)) begin
                if (r_owner == PORT_D) begin
                    r_dbus_rdata <= w_expire ? '0 : i_mem_rdata;
                end else begin
                    r_ibus_rdata <= w_expire ? '0 : i_mem_rdata;
                end
            end

            r_ibus_timeout <= w_expire && (r_owner == PORT_I);
            r_dbus_timeout <= w_expire && (r_owner == PORT_D);
        end
    end

    assign ibus.stall   = ibus.en && !(w_complete && (r_owner == PORT_I));
    assign dbus.stall   = dbus.en && !(w_complete && (r_owner == PORT_D));
    assign ibus.rdata   = r_ibus_rdata;
    assign dbus.rdata   = r_dbus_rdata;
    assign ibus.timeout = r_ibus_timeout;
    assign dbus.timeout = r_dbus_timeout;

    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: a scoreboard queue of expected memory accesses is checked as each access starts on the memory port.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t exp_q[$];
    acc_t cur;
    logic mon_prev_en;
    int   n_cmp;
    int   n_err;

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ibus_if ();
    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dbus_if ();

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .ibus        (ibus_if.slave),
        .dbus        (dbus_if.slave),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_done  (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        acc_t a;
        a.we = we;
        a.addr = addr;
        a.wdata = wdata;
        exp_q.push_back(a);
    endtask

    task automatic drive_i(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        ibus_if.en = en;
        ibus_if.we = we;
        ibus_if.addr = addr;
        ibus_if.wdata = wdata;
    endtask

    task automatic drive_d(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        dbus_if.en = en;
        dbus_if.we = we;
        dbus_if.addr = addr;
        dbus_if.wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Memory-port monitor: each new access must match the next scoreboard entry and stay stable while held.
    initial mon_prev_en = 1'b0;
    always @(negedge clk) begin
        if (mem_en && !mon_prev_en) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("acc_we", 64'(mem_we), 64'(cur.we));
                chk("acc_addr", 64'(mem_addr), 64'(cur.addr));
                chk("acc_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
        end else if (mem_en) begin
            chk("hold_we", 64'(mem_we), 64'(cur.we));
            chk("hold_addr", 64'(mem_addr), 64'(cur.addr));
            chk("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
        mon_prev_en = mem_en;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        mem_done = 1'b0;
        mem_rdata = '0;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        step();
        step();
        settle();
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_i_rdata", 64'(ibus_if.rdata), 64'd0);
        chk("rst_d_rdata", 64'(dbus_if.rdata), 64'd0);
        chk("rst_i_timeout", 64'(ibus_if.timeout), 64'd0);
        chk("rst_d_timeout", 64'(dbus_if.timeout), 64'd0);
        chk("rst_i_stall", 64'(ibus_if.stall), 64'd0);
        rst = 1'b0;

        // Lone ibus read, done in the first mem_en cycle.
        drive_i(1'b1, 4'h0, 32'h0000_1000, 32'h0);
        push(4'h0, 32'h0000_1000, 32'h0);
        settle();
        chk("t1_idle_stall", 64'(ibus_if.stall), 64'd1);
        chk("t1_idle_mem_en", 64'(mem_en), 64'd0);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_mem_en", 64'(mem_en), 64'd1);
        chk("t1_done_stall", 64'(ibus_if.stall), 64'd0);
        chk("t1_d_stall", 64'(dbus_if.stall), 64'd0);
        step();
        mem_done = 1'b0;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t1_i_rdata", 64'(ibus_if.rdata), 64'hDEAD_BEEF);
        chk("t1_mem_en_drop", 64'(mem_en), 64'd0);
        chk("t1_d_rdata", 64'(dbus_if.rdata), 64'd0);

        // Simultaneous requests: D first, then alternate while both stay asserted.
        drive_i(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        drive_d(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        push(4'h0, 32'h0000_0200, 32'h0);
        push(4'h0, 32'h0000_0100, 32'h0);
        push(4'h0, 32'h0000_0200, 32'h0);
        push(4'h0, 32'h0000_0100, 32'h0);
        settle();
        chk("t2_both_stall_i", 64'(ibus_if.stall), 64'd1);
        chk("t2_both_stall_d", 64'(dbus_if.stall), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            mem_done = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            settle();
            chk("t2_grant_addr", 64'(mem_addr), (k % 2 == 0) ? 64'h200 : 64'h100);
            chk("t2_d_stall", 64'(dbus_if.stall), (k % 2 == 0) ? 64'd0 : 64'd1);
            chk("t2_i_stall", 64'(ibus_if.stall), (k % 2 == 0) ? 64'd1 : 64'd0);
            step();
            mem_done = 1'b0;
            if (k == 3) begin
                drive_i(1'b0, 4'h0, 32'h0, 32'h0);
                drive_d(1'b0, 4'h0, 32'h0, 32'h0);
            end
            settle();
            chk("t2_bubble_mem_en", 64'(mem_en), 64'd0);
        end
        chk("t2_d_rdata", 64'(dbus_if.rdata), 64'hA000_0002);
        chk("t2_i_rdata", 64'(ibus_if.rdata), 64'hA000_0003);

        // dbus write completing in its third cycle.
        drive_d(1'b1, 4'b0011, 32'h0000_2004, 32'h1234_5678);
        push(4'b0011, 32'h0000_2004, 32'h1234_5678);
        settle();
        chk("t3_idle_stall", 64'(dbus_if.stall), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 2) mem_done = 1'b1;
            settle();
            chk("t3_mem_we", 64'(mem_we), 64'b0011);
            chk("t3_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
            chk("t3_d_stall", 64'(dbus_if.stall), (c == 2) ? 64'd0 : 64'd1);
        end
        step();
        mem_done = 1'b0;
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t3_d_rdata_kept", 64'(dbus_if.rdata), 64'hA000_0002);
        chk("t3_mem_en_drop", 64'(mem_en), 64'd0);

        // ibus redirect mid-flight: first result discarded, new address re-issued.
        drive_i(1'b1, 4'h0, 32'h0000_1000, 32'h0);
        push(4'h0, 32'h0000_1000, 32'h0);
        push(4'h0, 32'hBFC0_0380, 32'h0);
        step();
        ibus_if.addr = 32'hBFC0_0380;
        settle();
        chk("t4_redirect_stall", 64'(ibus_if.stall), 64'd1);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'h1111_1111;
        settle();
        chk("t4_mismatch_stall", 64'(ibus_if.stall), 64'd1);
        chk("t4_old_addr", 64'(mem_addr), 64'h1000);
        step();
        mem_done = 1'b0;
        settle();
        chk("t4_discard_rdata", 64'(ibus_if.rdata), 64'hA000_0003);
        chk("t4_bubble_mem_en", 64'(mem_en), 64'd0);
        chk("t4_bubble_stall", 64'(ibus_if.stall), 64'd1);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        settle();
        chk("t4_new_stall", 64'(ibus_if.stall), 64'd0);
        step();
        mem_done = 1'b0;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t4_i_rdata", 64'(ibus_if.rdata), 64'hCAFE_F00D);

        // Timeout after 8 busy cycles with no mem_done.
        drive_d(1'b1, 4'h0, 32'h0000_3000, 32'h0);
        push(4'h0, 32'h0000_3000, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("t5_mem_en", 64'(mem_en), 64'd1);
            chk("t5_d_stall", 64'(dbus_if.stall), (i == 7) ? 64'd0 : 64'd1);
            chk("t5_no_pulse_yet", 64'(dbus_if.timeout), 64'd0);
            step();
        end
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t5_mem_en_drop", 64'(mem_en), 64'd0);
        chk("t5_d_timeout", 64'(dbus_if.timeout), 64'd1);
        chk("t5_d_rdata_zero", 64'(dbus_if.rdata), 64'd0);
        chk("t5_i_timeout", 64'(ibus_if.timeout), 64'd0);
        step();
        settle();
        chk("t5_pulse_end", 64'(dbus_if.timeout), 64'd0);
        drive_i(1'b1, 4'h0, 32'h0000_4000, 32'h0);
        push(4'h0, 32'h0000_4000, 32'h0);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'h4444_0000;
        settle();
        chk("t5_next_stall", 64'(ibus_if.stall), 64'd0);
        step();
        mem_done = 1'b0;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t5_next_rdata", 64'(ibus_if.rdata), 64'h4444_0000);

        // mem_done in the expiry cycle wins over the timeout.
        drive_d(1'b1, 4'h0, 32'h0000_5000, 32'h0);
        push(4'h0, 32'h0000_5000, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                mem_done = 1'b1;
                mem_rdata = 32'h5A5A_5A5A;
            end
            settle();
            chk("t5b_d_stall", 64'(dbus_if.stall), (i == 7) ? 64'd0 : 64'd1);
            step();
        end
        mem_done = 1'b0;
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t5b_no_timeout", 64'(dbus_if.timeout), 64'd0);
        chk("t5b_d_rdata", 64'(dbus_if.rdata), 64'h5A5A_5A5A);
        chk("t5b_mem_en", 64'(mem_en), 64'd0);

        // Reset while busy abandons the access; afterwards the first tie goes to D again.
        drive_i(1'b1, 4'h0, 32'h0000_6000, 32'h0);
        push(4'h0, 32'h0000_6000, 32'h0);
        step();
        settle();
        chk("t6_busy", 64'(mem_en), 64'd1);
        rst = 1'b1;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        step();
        settle();
        chk("t6_mem_en", 64'(mem_en), 64'd0);
        chk("t6_i_rdata", 64'(ibus_if.rdata), 64'd0);
        chk("t6_d_rdata", 64'(dbus_if.rdata), 64'd0);
        rst = 1'b0;
        drive_i(1'b1, 4'h0, 32'h0000_7004, 32'h0);
        drive_d(1'b1, 4'h0, 32'h0000_7000, 32'h0);
        push(4'h0, 32'h0000_7000, 32'h0);
        push(4'h0, 32'h0000_7004, 32'h0);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'h7777_0000;
        settle();
        chk("t6_d_first", 64'(dbus_if.stall), 64'd0);
        step();
        mem_done = 1'b0;
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        step();
        mem_done = 1'b1;
        mem_rdata = 32'h7777_1111;
        settle();
        chk("t6_i_second", 64'(ibus_if.stall), 64'd0);
        step();
        mem_done = 1'b0;
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("t6_d_rdata_new", 64'(dbus_if.rdata), 64'h7777_0000);
        chk("t6_i_rdata_new", 64'(ibus_if.rdata), 64'h7777_1111);
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
